// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if
// Requester-side bus of the register-file write arbiter: packed per-requester
// valid/address/data from user logic and the one-hot ready (grant) returned.
// Requester i occupies bits [i*ADR_W +: ADR_W] of req_adr and
// [i*DATA_W +: DATA_W] of req_data.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADR_W   = 5,
  parameter int DATA_W  = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADR_W-1:0]  req_adr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  // User logic side: presents requests, receives the grant
  modport master (
    output req_valid,
    output req_adr,
    output req_data,
    input  req_ready
  );

  // Arbiter side: samples requests, drives the grant
  modport slave (
    input  req_valid,
    input  req_adr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the single write port of the 32x4 register-file BEL among NUM_REQ
// requesters. Round-robin arbitration is combinational in the request cycle;
// the winning address/data reach W_ADR/D/W_en through registers, so the write
// happens one cycle after the valid/ready handshake.
//
// Optional feature macro: REGFILE_WR_ARBITER_ARB_CLEAR_EN
//   When defined, reset enters a CLEAR state that writes zero to every entry
//   (addresses 0..2**ADR_W-1 ascending, one per cycle) with busy high and all
//   grants withheld; RUN follows. When undefined, reset goes straight to RUN
//   and busy is tied low.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADR_W   = 5,
  parameter int DATA_W  = 4
) (
  input  logic                UserCLK,
  input  logic                Reset,
  regfile_wr_arbiter_if.slave req_bus,
  output logic [ADR_W-1:0]    W_ADR,
  output logic [DATA_W-1:0]   D,
  output logic                W_en,
  output logic [2:0]          grant_id,
  output logic                busy
);

  // Pointer wide enough for indices 0..NUM_REQ-1; one extra bit for wrap math
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IDX_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Next round-robin start: one past the winner, wrapping at NUM_REQ
  function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] win);
    logic [PTR_W-1:0] nxt;
    if (win == LAST_IDX) begin
      nxt = '0;
    end else begin
      nxt = win + PTR_W'(1);
    end
    return nxt;
  endfunction

  logic [PTR_W-1:0]   rr_ptr_r;
  logic [ADR_W-1:0]   w_adr_r;
  logic [DATA_W-1:0]  d_r;
  logic               w_en_r;
  logic [2:0]         grant_id_r;

  logic               run_s;
  logic [IDX_W-1:0]   idx_s;
  logic               found_s;
  logic [PTR_W-1:0]   win_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic               accept_s;
  logic [ADR_W-1:0]   win_adr_s;
  logic [DATA_W-1:0]  win_data_s;

  // Round-robin search from rr_ptr_r; the first valid requester wins.
  // The grant depends only on valid, the pointer and the state, never on ready.
  always_comb begin
    idx_s   = '0;
    found_s = 1'b0;
    win_s   = '0;
    gnt_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = {1'b0, rr_ptr_r} + IDX_W'(k);
      if (idx_s >= IDX_W'(NUM_REQ)) begin
        idx_s = idx_s - IDX_W'(NUM_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (run_s && !found_s && req_bus.req_valid[idx_s[PTR_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[PTR_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      gnt_s[win_s] = 1'b1;
    end else begin
      gnt_s = '0;
    end
  end

  // One-hot AND-OR mux of the winner's address and data
  always_comb begin
    win_adr_s  = '0;
    win_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_adr_s  = win_adr_s  | ({ADR_W{gnt_s[i]}}  & req_bus.req_adr[i*ADR_W +: ADR_W]);
      win_data_s = win_data_s | ({DATA_W{gnt_s[i]}} & req_bus.req_data[i*DATA_W +: DATA_W]);
    end
  end

  // A grant is only issued to a valid requester, so a grant is a transfer
  assign accept_s = |gnt_s;

  assign req_bus.req_ready = gnt_s;
  assign W_ADR             = w_adr_r;
  assign D                 = d_r;
  assign W_en              = w_en_r;
  assign grant_id          = grant_id_r;

`ifdef REGFILE_WR_ARBITER_ARB_CLEAR_EN

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [ADR_W-1:0] CLR_LAST = '1;

  state_t           state_r;
  logic [ADR_W-1:0] clr_cnt_r;
  logic             busy_r;

  assign run_s = (state_r == ST_RUN);
  assign busy  = busy_r;

  // Controller: zero-fill sweep after reset, then one arbitrated write per cycle.
  // busy drops on the edge that launches the last clear write, so RUN (and the
  // first grant) overlaps the cycle in which the last entry is written.
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_r    <= ST_CLEAR;
      clr_cnt_r  <= '0;
      busy_r     <= 1'b1;
      rr_ptr_r   <= '0;
      w_adr_r    <= '0;
      d_r        <= '0;
      w_en_r     <= 1'b0;
      grant_id_r <= 3'd0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          w_en_r    <= 1'b1;
          w_adr_r   <= clr_cnt_r;
          d_r       <= '0;
          clr_cnt_r <= clr_cnt_r + ADR_W'(1);
          if (clr_cnt_r == CLR_LAST) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_CLEAR;
            busy_r  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            w_en_r     <= 1'b1;
            w_adr_r    <= win_adr_s;
            d_r        <= win_data_s;
            grant_id_r <= 3'(win_s);
            rr_ptr_r   <= rr_next(win_s);
          end else begin
            w_en_r     <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_CLEAR;
          clr_cnt_r <= '0;
          busy_r    <= 1'b1;
          w_en_r    <= 1'b0;
        end
      endcase
    end
  end

`else

  assign run_s = 1'b1;
  assign busy  = 1'b0;

  // Write-port registers: capture the winner on acceptance, otherwise idle the
  // write enable and hold address/data
  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      rr_ptr_r   <= '0;
      w_adr_r    <= '0;
      d_r        <= '0;
      w_en_r     <= 1'b0;
      grant_id_r <= 3'd0;
    end else if (accept_s) begin
      w_en_r     <= 1'b1;
      w_adr_r    <= win_adr_s;
      d_r        <= win_data_s;
      grant_id_r <= 3'(win_s);
      rr_ptr_r   <= rr_next(win_s);
    end else begin
      w_en_r     <= 1'b0;
    end
  end

`endif

endmodule
